// File: rtl/dma_xfer_scheduler.sv
// DMA transfer scheduler: splits one transfer into FIFO-sized chunks, waits for
// downstream FIFO space before each chunk, issues a start pulse to the DMA
// master and tracks completion with a per-chunk timeout.
module dma_xfer_scheduler #(
  parameter int FIFO_DEPTH    = 32,
  parameter int CHUNK_TIMEOUT = 1023
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_Start,
  input  logic        i_Abort,
  input  logic [31:0] i_Base_Addr,
  input  logic [15:0] i_Total_Words,
  input  logic [5:0]  i_Chunk_Words,
  input  logic [5:0]  i_FIFO_data_count,
  input  logic        i_Chunk_Done,
  output logic        o_CoreSystemStart,
  output logic [5:0]  o_RCC_BUFFER_LENGTH,
  output logic [15:0] o_RCC_DMA_ADDR_HIGH,
  output logic [15:0] o_RCC_DMA_ADDR_LOW,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error,
  output logic [15:0] o_Words_Remaining
);

  localparam int TW = (CHUNK_TIMEOUT < 2) ? 1 : $clog2(CHUNK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_SPACE, S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_COMPLETE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   rem_q, rem_d;
  logic [5:0]    cfg_q, cfg_d;
  logic [5:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [6:0]    depth7, cnt7, free7;
  logic [5:0]    eff_chunk, chunk_len;

  // Free FIFO space (clamped at zero if occupancy exceeds depth) and next chunk size.
  always_comb begin
    depth7    = 7'(FIFO_DEPTH);
    cnt7      = {1'b0, i_FIFO_data_count};
    free7     = (cnt7 >= depth7) ? 7'd0 : (depth7 - cnt7);
    eff_chunk = (cfg_q == 6'd0) ? 6'd1 : cfg_q;
    chunk_len = (rem_q < {10'd0, eff_chunk}) ? rem_q[5:0] : eff_chunk;
  end

  // Next-state and datapath; outputs are derived from the next state so the
  // registered copies line up with the state they describe.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cfg_d   = cfg_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (i_Abort) begin
      // Abort beats chunk-done and timeout; error flag keeps its value.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_Start) begin
          addr_d  = i_Base_Addr;
          rem_d   = i_Total_Words;
          cfg_d   = i_Chunk_Words;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          len_d   = chunk_len;
          state_d = (rem_q == 16'd0) ? S_COMPLETE : S_WAIT_SPACE;
        end
        S_WAIT_SPACE: if (free7 >= {1'b0, len_q}) state_d = S_ISSUE;
        S_ISSUE: begin
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          tmo_d = tmo_q + 1'b1;
          if (i_Chunk_Done) begin
            state_d = S_ADVANCE;
          end else if (tmo_d == TW'(CHUNK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_ADVANCE: begin
          addr_d  = addr_q + {24'd0, len_q, 2'b00};
          rem_d   = rem_q - {10'd0, len_q};
          state_d = S_LOAD;
        end
        S_COMPLETE: state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
    start_d = (state_d == S_ISSUE);
    done_d  = (state_d == S_COMPLETE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cfg_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cfg_q   <= cfg_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_CoreSystemStart   = start_q;
  assign o_RCC_BUFFER_LENGTH = len_q;
  assign o_RCC_DMA_ADDR_HIGH = addr_q[31:16];
  assign o_RCC_DMA_ADDR_LOW  = addr_q[15:0];
  assign o_Busy              = busy_q;
  assign o_Done              = done_q;
  assign o_Error             = err_q;
  assign o_Words_Remaining   = rem_q;

endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// Directed bench for dma_xfer_scheduler: chunking, FIFO-space stall, timeout,
// address wrap, abort and mid-transfer reset.
module tb_dma_xfer_scheduler;

  logic        HCLK, HRESETn;
  logic        i_Start, i_Abort, i_Chunk_Done;
  logic [31:0] i_Base_Addr;
  logic [15:0] i_Total_Words;
  logic [5:0]  i_Chunk_Words, i_FIFO_data_count;
  logic        o_CoreSystemStart, o_Busy, o_Done, o_Error;
  logic [5:0]  o_RCC_BUFFER_LENGTH;
  logic [15:0] o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW, o_Words_Remaining;

  int n_cmp = 0;
  int n_err = 0;
  int st_cnt = 0;
  int done_cnt = 0;

  dma_xfer_scheduler #(.FIFO_DEPTH(32), .CHUNK_TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_Start(i_Start), .i_Abort(i_Abort),
    .i_Base_Addr(i_Base_Addr), .i_Total_Words(i_Total_Words),
    .i_Chunk_Words(i_Chunk_Words), .i_FIFO_data_count(i_FIFO_data_count),
    .i_Chunk_Done(i_Chunk_Done), .o_CoreSystemStart(o_CoreSystemStart),
    .o_RCC_BUFFER_LENGTH(o_RCC_BUFFER_LENGTH),
    .o_RCC_DMA_ADDR_HIGH(o_RCC_DMA_ADDR_HIGH),
    .o_RCC_DMA_ADDR_LOW(o_RCC_DMA_ADDR_LOW), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Error(o_Error), .o_Words_Remaining(o_Words_Remaining)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // pulse counters, sampled on the falling edge
  always @(negedge HCLK) begin
    if (o_CoreSystemStart === 1'b1) st_cnt++;
    if (o_Done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [31:0] base, input logic [15:0] tot, input logic [5:0] ch);
    @(negedge HCLK);
    i_Base_Addr = base; i_Total_Words = tot; i_Chunk_Words = ch; i_Start = 1'b1;
    @(negedge HCLK);
    i_Start = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (o_CoreSystemStart !== 1'b1 && n < budget);
    chk(tag, o_CoreSystemStart, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (o_Done !== 1'b1 && n < budget);
    chk(tag, o_Done, 1);
  endtask

  task automatic pulse_done();
    @(negedge HCLK); i_Chunk_Done = 1'b1;
    @(negedge HCLK); i_Chunk_Done = 1'b0;
  endtask

  task automatic chk_chunk(input string tag, input logic [5:0] len, input logic [31:0] addr);
    chk({tag, "_len"}, o_RCC_BUFFER_LENGTH, len);
    chk({tag, "_addr"}, {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, addr);
  endtask

  // overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "bench timed out");
  end

  initial begin
    int s0, d0, n;
    logic [5:0] exp_len [3];
    logic [31:0] exp_addr [3];
    exp_len  = '{6'd4, 6'd4, 6'd2};
    exp_addr = '{32'h1000, 32'h1010, 32'h1020};

    HRESETn = 1'b0; i_Start = 0; i_Abort = 0; i_Chunk_Done = 0;
    i_Base_Addr = '0; i_Total_Words = '0; i_Chunk_Words = '0; i_FIFO_data_count = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_busy", o_Busy, 0);
    chk("rst_start", o_CoreSystemStart, 0);
    chk("rst_len", o_RCC_BUFFER_LENGTH, 0);
    chk("rst_rem", o_Words_Remaining, 0);
    HRESETn = 1'b1;

    // 10 words in chunks of 4: 4,4,2
    s0 = st_cnt; d0 = done_cnt;
    go(32'h0000_1000, 16'd10, 6'd4);
    chk("s1_busy", o_Busy, 1);
    chk("s1_rem0", o_Words_Remaining, 10);
    for (int i = 0; i < 3; i++) begin
      wait_start("s1_start", 10);
      chk_chunk("s1", exp_len[i], exp_addr[i]);
      pulse_done();
    end
    wait_done("s1_done", 10);
    repeat (3) @(negedge HCLK);
    chk("s1_nstart", st_cnt - s0, 3);
    chk("s1_ndone", done_cnt - d0, 1);
    chk("s1_rem", o_Words_Remaining, 0);
    chk("s1_idle", o_Busy, 0);

    // zero-length transfer completes without a chunk
    s0 = st_cnt; d0 = done_cnt;
    go(32'h0000_2000, 16'd0, 6'd4);
    n = 1;
    while (o_Done !== 1'b1 && n < 3) begin
      @(negedge HCLK);
      n++;
    end
    chk("s2_done", o_Done, 1);
    repeat (3) @(negedge HCLK);
    chk("s2_nstart", st_cnt - s0, 0);
    chk("s2_ndone", done_cnt - d0, 1);

    // FIFO space stall: count 30 then 25 (free 2, 7) hold; 24 (free 8) goes
    s0 = st_cnt;
    i_FIFO_data_count = 6'd30;
    go(32'h0000_4000, 16'd8, 6'd8);
    repeat (8) @(negedge HCLK);
    i_FIFO_data_count = 6'd25;
    repeat (8) @(negedge HCLK);
    chk("s3_stall", st_cnt - s0, 0);
    chk("s3_busy", o_Busy, 1);
    i_FIFO_data_count = 6'd24;
    @(negedge HCLK);
    chk("s3_go", o_CoreSystemStart, 1);
    chk_chunk("s3", 6'd8, 32'h4000);
    pulse_done();
    wait_done("s3_done", 10);
    i_FIFO_data_count = 6'd0;
    repeat (2) @(negedge HCLK);

    // timeout after 16 WAIT_DONE cycles, no done pulse
    d0 = done_cnt;
    go(32'h0000_5000, 16'd4, 6'd4);
    wait_start("s4_start", 10);
    n = 0;
    while (o_Error !== 1'b1 && n < 40) begin
      @(negedge HCLK);
      n++;
    end
    chk("s4_err", o_Error, 1);
    chk("s4_cycles", n, 17);
    chk("s4_idle", o_Busy, 0);
    repeat (3) @(negedge HCLK);
    chk("s4_nodone", done_cnt - d0, 0);
    chk("s4_sticky", o_Error, 1);
    go(32'h0, 16'd0, 6'd1);
    chk("s4_clr", o_Error, 0);
    wait_done("s4_done2", 5);
    repeat (2) @(negedge HCLK);

    // address wrap past 2^32
    go(32'hFFFF_FFF8, 16'd4, 6'd2);
    wait_start("s5_start0", 10);
    chk_chunk("s5_c0", 6'd2, 32'hFFFF_FFF8);
    pulse_done();
    wait_start("s5_start1", 10);
    chk_chunk("s5_c1", 6'd2, 32'h0000_0000);
    pulse_done();
    wait_done("s5_done", 10);
    repeat (2) @(negedge HCLK);

    // chunk size 0 behaves as 1
    go(32'h0000_0100, 16'd2, 6'd0);
    wait_start("s7_start0", 10);
    chk_chunk("s7_c0", 6'd1, 32'h100);
    pulse_done();
    wait_start("s7_start1", 10);
    chk_chunk("s7_c1", 6'd1, 32'h104);
    pulse_done();
    wait_done("s7_done", 10);
    repeat (2) @(negedge HCLK);

    // abort together with chunk done
    s0 = st_cnt; d0 = done_cnt;
    go(32'h0000_2000, 16'd8, 6'd4);
    wait_start("s6_start", 10);
    @(negedge HCLK);
    i_Abort = 1'b1; i_Chunk_Done = 1'b1;
    @(negedge HCLK);
    i_Abort = 1'b0; i_Chunk_Done = 1'b0;
    chk("s6_idle", o_Busy, 0);
    chk("s6_err", o_Error, 0);
    repeat (10) @(negedge HCLK);
    chk("s6_nodone", done_cnt - d0, 0);
    chk("s6_nstart", st_cnt - s0, 1);

    // start and abort together in IDLE stays idle
    @(negedge HCLK);
    i_Total_Words = 16'd4; i_Start = 1'b1; i_Abort = 1'b1;
    @(negedge HCLK);
    i_Start = 1'b0; i_Abort = 1'b0;
    chk("s6_startabort", o_Busy, 0);

    // reset mid-transfer
    go(32'h0000_3000, 16'd20, 6'd4);
    wait_start("s8_start0", 10);
    pulse_done();
    wait_start("s8_start1", 10);
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    s0 = st_cnt;
    chk("s8_busy", o_Busy, 0);
    chk("s8_addr", {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, 0);
    chk("s8_len", o_RCC_BUFFER_LENGTH, 0);
    chk("s8_rem", o_Words_Remaining, 0);
    chk("s8_flags", {o_CoreSystemStart, o_Done, o_Error}, 0);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);
    chk("s8_nostart", st_cnt - s0, 0);
    chk("s8_idle", o_Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_xfer_scheduler.md
DMA_XFER_SCHEDULER -- requirements
Module: dma_xfer_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 32, SHALL be the word capacity of the downstream async FIFO.
REQ-002 Parameter CHUNK_TIMEOUT, default 1023, SHALL be the maximum cycles spent waiting for one chunk's completion.
REQ-003 HCLK  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 HRESETn  in  1  reset; it SHALL be synchronous and active-low.
REQ-005 i_Start  in  1  one-cycle transfer request, honoured only in IDLE.
REQ-006 i_Abort  in  1  cancels any transfer in progress.
REQ-007 i_Base_Addr  in  32  byte address of the first word.
REQ-008 i_Total_Words  in  16  words to move in the whole transfer.
REQ-009 i_Chunk_Words  in  6  maximum words per DMA chunk.
REQ-010 i_FIFO_data_count  in  6  current FIFO occupancy, write side.
REQ-011 i_Chunk_Done  in  1  one-cycle pulse from the DMA master marking the end of the current chunk.
REQ-012 o_CoreSystemStart  out  1  one-cycle chunk-start pulse to the DMA master.
REQ-013 o_RCC_BUFFER_LENGTH  out  6  word count of the current chunk.
REQ-014 o_RCC_DMA_ADDR_HIGH / o_RCC_DMA_ADDR_LOW  out  16 each  upper and lower halves of the current chunk address.
REQ-015 o_Busy  out  1  high whenever the state is not IDLE.
REQ-016 o_Done  out  1  one-cycle pulse on successful completion.
REQ-017 o_Error  out  1  sticky timeout flag, cleared by i_Start or by reset.
REQ-018 o_Words_Remaining  out  16  words not yet transferred.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, WAIT_SPACE, ISSUE, WAIT_DONE, ADVANCE and COMPLETE.
REQ-020 IDLE with i_Start=1 SHALL do the following:
- latch i_Base_Addr, i_Total_Words and i_Chunk_Words;
- clear o_Error;
- go to LOAD.
REQ-021 LOAD SHALL compute chunk = min(effective chunk, remaining), where an i_Chunk_Words value of 0 is treated as 1.
REQ-022 LOAD with remaining = 0 SHALL go to COMPLETE without issuing any chunk; otherwise LOAD SHALL go to WAIT_SPACE.
REQ-023 WAIT_SPACE SHALL go to ISSUE only when (FIFO_DEPTH - i_FIFO_data_count) >= chunk, computed 7 bits wide with no underflow, and SHALL hold otherwise.
REQ-024 ISSUE SHALL assert o_CoreSystemStart for exactly that one cycle, reset the timeout counter, and go to WAIT_DONE.
REQ-025 o_RCC_BUFFER_LENGTH and the address outputs SHALL be valid from the ISSUE cycle and SHALL stay stable until ADVANCE.
REQ-026 In WAIT_DONE, i_Chunk_Done SHALL move the FSM to ADVANCE.
REQ-027 The WAIT_DONE timeout counter SHALL increment every cycle; reaching CHUNK_TIMEOUT SHALL set o_Error and return the FSM to IDLE without asserting o_Done.
REQ-028 i_Chunk_Done in any state other than WAIT_DONE SHALL be ignored.
REQ-029 ADVANCE SHALL do the following, then return to LOAD:
- address += chunk*4, modulo 2^32, wrapping silently;
- remaining -= chunk.
REQ-030 COMPLETE SHALL pulse o_Done for one cycle and go to IDLE.
REQ-031 i_Abort in any non-IDLE state SHALL force IDLE on the next edge with no o_Done and no o_CoreSystemStart in that next cycle.
REQ-032 i_Abort SHALL win over a simultaneous i_Chunk_Done or timeout, and o_Error SHALL be unchanged by an abort.
REQ-033 i_Start outside IDLE SHALL be ignored; i_Start and i_Abort together in IDLE SHALL be treated as abort, so the FSM stays in IDLE.
REQ-034 o_Words_Remaining SHALL reflect the latched remaining count, updated in ADVANCE.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 With HRESETn=0 at an edge, the block SHALL enter IDLE and clear all outputs to 0, including o_Error, o_Words_Remaining, the address and the length.
REQ-037 Reset mid-transfer SHALL discard all latched transfer state, and the block SHALL issue no further start pulses.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Base 0x0000_1000, total 10, chunk 4, FIFO count 0 -> three start pulses with lengths 4,4,2 at addresses 0x1000, 0x1010, 0x1020; o_Done once; remaining ends at 0.
- Total 0 -> o_Done within 3 cycles of i_Start; no o_CoreSystemStart.
- Chunk 8, FIFO count 30 with depth 32 -> stalls in WAIT_SPACE; drop count to 24 -> start pulse on the following cycle.
- CHUNK_TIMEOUT=16 with no i_Chunk_Done -> o_Error=1, state IDLE, o_Done=0; next i_Start clears o_Error.
- Base 0xFFFF_FFF8, total 4, chunk 2 -> second chunk at 0x0000_0000 (wrap).
- i_Abort coincident with i_Chunk_Done -> IDLE, no o_Done; HRESETn low mid-transfer -> all outputs 0, no further starts.
